ps2_char_buffer: RTL and testbench
==================================

PS2_CHAR_BUFFER -- requirements
Module: ps2_char_buffer

Interface
REQ-001 SHALL have parameter COLS, default 16: characters per text row, 2..64.
REQ-002 SHALL have parameter ROWS, default 12: text rows, 2..64.
REQ-003 SHALL have parameter WRAP, default 1: 1 = wrap to cell 0 when full; 0 = drop characters when full.
REQ-004 SHALL have ports: iCLK  in  1  sole clock. All logic is rising-edge.
REQ-005 SHALL have ports: iRST_N  in  1  reset. Synchronous, active-low.
REQ-006 SHALL have ports: iStrobe  in  1  keyboard data-ready level or pulse, already in the iCLK domain.
REQ-007 SHALL have ports: iAscii  in  8  character code, valid while iStrobe is high.
REQ-008 SHALL have ports: iClear  in  1  one-cycle request to clear the screen.
REQ-009 SHALL have ports: iRd_Addr  in  clog2(COLS*ROWS)  display read address.
REQ-010 SHALL have ports: oRd_Data  out  8  cell contents, returned one cycle after iRd_Addr.
REQ-011 SHALL have ports: oCur_Col  out  6  and  oCur_Row  out  6  cursor position.
REQ-012 SHALL have ports: oCount  out  clog2(COLS*ROWS)+1  number of occupied cells.
REQ-013 SHALL have ports: oFull  out  1;  oEmpty  out  1;  oBusy  out  1  (high while clearing).

Function
REQ-014 SHALL contain a COLS*ROWS x 8 memory, cell address = row*COLS+col; no other write port exists.
REQ-015 SHALL register iStrobe each cycle; an event is iStrobe==1 with previous sample 0, so a held level produces exactly one event.
REQ-016 SHALL use states IDLE and CLEAR; events are processed only in IDLE; events arriving in CLEAR are discarded.
REQ-017 On a printable event (0x20..0x7E), SHALL write iAscii at the cursor on the detecting edge, then advance col; col==COLS-1 -> col 0, row+1; oCount+1.
REQ-018 On 0x08 (backspace) with oCount>0, SHALL step the cursor back one cell (col 0 -> COLS-1, row-1), write 0x20 there, and decrement oCount; when oCount==0 it SHALL do nothing.
REQ-019 On 0x0D (enter), SHALL fill the rest of the row with 0x20, one cell per cycle, counting each cell in oCount; after the last cell, col=0, row+1; the FSM stays in IDLE but ignores further events until the fill ends.
REQ-020 All other codes SHALL be ignored.
REQ-021 When full (oCount==COLS*ROWS) with WRAP=1, cursor SHALL return to (0,0), oCount SHALL stay at max, and new writes overwrite.
REQ-022 When full with WRAP=0, printable events and enter SHALL be dropped; backspace SHALL still act.
REQ-023 iClear in IDLE SHALL enter CLEAR and write 0x20 to addresses 0..COLS*ROWS-1, one per cycle, with oBusy=1.
REQ-024 On leaving CLEAR, cursor SHALL be (0,0), oCount=0, and the state returns to IDLE exactly COLS*ROWS cycles after entry.
REQ-025 iClear while already in CLEAR SHALL be ignored.
REQ-026 iClear and an event in the same cycle: clear SHALL win and the event is dropped.
REQ-027 The read port SHALL be synchronous with 1-cycle latency. A read and a write to the same address in the same cycle SHALL return the old data.
REQ-028 oFull and oEmpty SHALL be combinational decodes of oCount.

Reset
REQ-029 With iRST_N low at a clock edge, SHALL set: state IDLE, cursor (0,0), oCount 0, oEmpty 1, oFull 0, oBusy 0, strobe history 0, and oRd_Data 0x00.
REQ-030 Reset SHALL NOT initialise memory contents; reset during CLEAR or an enter fill SHALL abort it immediately.

Configuration
REQ-031 With macro PS2_CHAR_BUFFER_DIGIT_EN defined, SHALL add output oLast_Digit [3:0]: the binary value of the last written character when it is '0'..'9' (0x30..0x39); any other character gives 0x0; reset value 0x0.
REQ-032 Without PS2_CHAR_BUFFER_DIGIT_EN, the port and its logic SHALL be absent.

Verification
REQ-033 Reset, then strobe 'A' (0x41) with iStrobe held high 5 cycles -> cell 0 = 0x41, oCount=1, cursor (1,0), only one write.
REQ-034 COLS=4, ROWS=2, WRAP=0: 9 printable strobes -> oFull=1 after 8th, 9th dropped, cell 0 unchanged; WRAP=1 -> cell 0 holds the 9th character.
REQ-035 Type 'a','b', then 0x08 x3 -> cell 1 = 0x20, oCount 0, cursor (0,0), oEmpty=1, third backspace no-op.
REQ-036 Default params: 'x' then 0x0D -> cells 1..15 = 0x20, cursor (0,1), oCount=16, event during the fill ignored.
REQ-037 iClear together with strobe 'Z' -> oBusy high for exactly 192 cycles, all cells 0x20, 'Z' not written, oCount 0.
REQ-038 With PS2_CHAR_BUFFER_DIGIT_EN: strobe '7' (0x37) -> oLast_Digit=7; then 'q' -> 0.

Source files
------------

// File: rtl/ps2_char_buffer.sv
// ps2_char_buffer: text-mode character buffer fed by a PS/2 keyboard decoder.
// Keystrokes arrive as ASCII codes with a data-ready strobe and are placed at a
// cursor in a COLS x ROWS cell memory that a display engine scans through a
// synchronous read port. Supports printable characters, backspace, enter
// (blank-fill to end of row) and a full-screen clear.
// Optional feature: define PS2_CHAR_BUFFER_DIGIT_EN to add oLast_Digit, the
// binary value of the most recently written character when it is '0'..'9'.
module ps2_char_buffer #(
   parameter int COLS = 16,
   parameter int ROWS = 12,
   parameter int WRAP = 1
) (
   input  logic                              iCLK,
   input  logic                              iRST_N,
   input  logic                              iStrobe,
   input  logic [7:0]                        iAscii,
   input  logic                              iClear,
   input  logic [$clog2(COLS*ROWS)-1:0]      iRd_Addr,
   output logic [7:0]                        oRd_Data,
   output logic [5:0]                        oCur_Col,
   output logic [5:0]                        oCur_Row,
   output logic [$clog2(COLS*ROWS):0]        oCount,
   output logic                              oFull,
   output logic                              oEmpty,
   output logic                              oBusy
`ifdef PS2_CHAR_BUFFER_DIGIT_EN
   ,
   output logic [3:0]                        oLast_Digit
`endif
);

   localparam int CELLS = COLS * ROWS;
   localparam int AW    = $clog2(CELLS);

   localparam logic [5:0]    LAST_COL  = 6'(COLS - 1);
   localparam logic [5:0]    LAST_ROW  = 6'(ROWS - 1);
   localparam logic [AW:0]   MAX_COUNT = (AW + 1)'(CELLS);
   localparam logic [AW-1:0] LAST_ADDR = AW'(CELLS - 1);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t          state;
   logic [7:0]      mem [CELLS];
   logic [7:0]      rd_data;
   logic            strobe_q;
   logic            filling;
   logic [5:0]      col;
   logic [5:0]      row;
   logic [AW:0]     count;
   logic [AW-1:0]   clr_addr;

   logic            event_hit;
   logic            is_print;
   logic            full;
   logic            empty;
   logic            blocked;
   logic            act_clear;
   logic            act_print;
   logic            act_bs;
   logic            act_space;
   logic [5:0]      next_col;
   logic [5:0]      next_row;
   logic [5:0]      back_col;
   logic [5:0]      back_row;
   logic [AW-1:0]   cur_addr;
   logic [AW-1:0]   back_addr;
   logic            wr_en;
   logic [AW-1:0]   wr_addr;
   logic [7:0]      wr_data;

   assign full      = (count == MAX_COUNT);
   assign empty     = (count == '0);
   assign event_hit = iStrobe & ~strobe_q;
   assign is_print  = (iAscii >= 8'h20) && (iAscii <= 8'h7E);
   assign blocked   = full && (WRAP == 0);
   assign cur_addr  = AW'(int'(row) * COLS + int'(col));
   assign back_addr = AW'(int'(back_row) * COLS + int'(back_col));

   // Pick the single action for this cycle: clear beats an ongoing enter fill,
   // which in turn locks out any new keystroke event until it finishes.
   always_comb begin
      act_clear = 1'b0;
      act_print = 1'b0;
      act_bs    = 1'b0;
      act_space = 1'b0;
      if (state == IDLE) begin
         if (iClear) begin
            act_clear = 1'b1;
         end else if (filling) begin
            act_space = 1'b1;
         end else if (event_hit) begin
            if (is_print && !blocked) begin
               act_print = 1'b1;
            end else if ((iAscii == 8'h08) && !empty) begin
               act_bs = 1'b1;
            end else if ((iAscii == 8'h0D) && !blocked) begin
               act_space = 1'b1;
            end
         end
      end
   end

   // Cursor one cell forward and one cell back, wrapping at row and screen ends.
   always_comb begin
      next_col = col + 6'd1;
      next_row = row;
      if (col == LAST_COL) begin
         next_col = '0;
         next_row = (row == LAST_ROW) ? 6'd0 : row + 6'd1;
      end
      back_col = col - 6'd1;
      back_row = row;
      if (col == '0) begin
         back_col = LAST_COL;
         back_row = (row == '0) ? LAST_ROW : row - 6'd1;
      end
   end

   // The one and only memory write port: clear sweep, character, or blank.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = cur_addr;
      wr_data = 8'h20;
      if (state == CLEAR) begin
         wr_en   = 1'b1;
         wr_addr = clr_addr;
      end else if (act_print) begin
         wr_en   = 1'b1;
         wr_data = iAscii;
      end else if (act_bs) begin
         wr_en   = 1'b1;
         wr_addr = back_addr;
      end else if (act_space) begin
         wr_en   = 1'b1;
      end
   end

   // Control FSM: cursor, occupancy count, enter fill and the clear sweep.
   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         state    <= IDLE;
         strobe_q <= 1'b0;
         filling  <= 1'b0;
         col      <= '0;
         row      <= '0;
         count    <= '0;
         clr_addr <= '0;
      end else begin
         strobe_q <= iStrobe;
         case (state)
            IDLE: begin
               if (act_clear) begin
                  state    <= CLEAR;
                  filling  <= 1'b0;
                  clr_addr <= '0;
               end else if (act_print) begin
                  col <= next_col;
                  row <= next_row;
                  if (!full) count <= count + 1'b1;
               end else if (act_bs) begin
                  col   <= back_col;
                  row   <= back_row;
                  count <= count - 1'b1;
               end else if (act_space) begin
                  col     <= next_col;
                  row     <= next_row;
                  filling <= (col != LAST_COL);
                  if (!full) count <= count + 1'b1;
               end
            end
            CLEAR: begin
               clr_addr <= clr_addr + 1'b1;
               if (clr_addr == LAST_ADDR) begin
                  state <= IDLE;
                  col   <= '0;
                  row   <= '0;
                  count <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Cell storage; contents deliberately survive reset, writes are held off.
   always_ff @(posedge iCLK) begin
      if (iRST_N && wr_en) mem[wr_addr] <= wr_data;
   end

   // Registered display read; a same-cycle write is seen one read later.
   always_ff @(posedge iCLK) begin
      if (!iRST_N) rd_data <= 8'h00;
      else         rd_data <= mem[iRd_Addr];
   end

`ifdef PS2_CHAR_BUFFER_DIGIT_EN
   logic [3:0] last_digit;

   // Track the numeric value of the latest write, zero for non-digits.
   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         last_digit <= 4'h0;
      end else if (wr_en) begin
         last_digit <= ((wr_data >= 8'h30) && (wr_data <= 8'h39)) ? wr_data[3:0] : 4'h0;
      end
   end

   assign oLast_Digit = last_digit;
`endif

   assign oRd_Data = rd_data;
   assign oCur_Col = col;
   assign oCur_Row = row;
   assign oCount   = count;
   assign oFull    = full;
   assign oEmpty   = empty;
   assign oBusy    = (state == CLEAR);

endmodule

// File: tb/tb_ps2_char_buffer.sv
// tb_ps2_char_buffer: drives three buffers (16x12 wrapping, 4x2 dropping,
// 4x2 wrapping) from one shared keyboard stream and compares them with a
// linear-position model of the screen kept in plain arrays.
module tb_ps2_char_buffer;

   logic       CLOCK_50 = 1'b0;
   logic       rst_n;
   logic       strobe;
   logic       clear;
   logic [7:0] ascii;

   logic [7:0] rd_addr0;
   logic [2:0] rd_addr1;
   logic [2:0] rd_addr2;
   logic [7:0] rd_data0, rd_data1, rd_data2;
   logic [5:0] col0, row0, col1, row1, col2, row2;
   logic [8:0] cnt0;
   logic [3:0] cnt1, cnt2;
   logic       full0, full1, full2;
   logic       empty0, empty1, empty2;
   logic       busy0, busy1, busy2;
`ifdef PS2_CHAR_BUFFER_DIGIT_EN
   logic [3:0] digit0;
`endif

   int compare_count  = 0;
   int mismatch_count = 0;

   // screen model: linear cursor position, count and cell bytes (-1 = unknown)
   int m_cols [3] = '{16, 4, 4};
   int m_rows [3] = '{12, 2, 2};
   int m_wrap [3] = '{1, 0, 1};
   int m_mem  [3][192];
   int m_pos  [3];
   int m_cnt  [3];

   logic [7:0] chars [9];
   int         n0, n1, n2;
   int         r, hold, gap;
   logic [7:0] code;
   logic [7:0] others [8] = '{8'h00, 8'h07, 8'h0A, 8'h1B, 8'h7F, 8'h80, 8'hFF, 8'h1F};

   ps2_char_buffer dut0 (
      .iCLK(CLOCK_50), .iRST_N(rst_n), .iStrobe(strobe), .iAscii(ascii), .iClear(clear),
      .iRd_Addr(rd_addr0), .oRd_Data(rd_data0), .oCur_Col(col0), .oCur_Row(row0),
      .oCount(cnt0), .oFull(full0), .oEmpty(empty0), .oBusy(busy0)
`ifdef PS2_CHAR_BUFFER_DIGIT_EN
      , .oLast_Digit(digit0)
`endif
   );

   ps2_char_buffer #(.COLS(4), .ROWS(2), .WRAP(0)) dut1 (
      .iCLK(CLOCK_50), .iRST_N(rst_n), .iStrobe(strobe), .iAscii(ascii), .iClear(clear),
      .iRd_Addr(rd_addr1), .oRd_Data(rd_data1), .oCur_Col(col1), .oCur_Row(row1),
      .oCount(cnt1), .oFull(full1), .oEmpty(empty1), .oBusy(busy1)
`ifdef PS2_CHAR_BUFFER_DIGIT_EN
      , .oLast_Digit()
`endif
   );

   ps2_char_buffer #(.COLS(4), .ROWS(2), .WRAP(1)) dut2 (
      .iCLK(CLOCK_50), .iRST_N(rst_n), .iStrobe(strobe), .iAscii(ascii), .iClear(clear),
      .iRd_Addr(rd_addr2), .oRd_Data(rd_data2), .oCur_Col(col2), .oCur_Row(row2),
      .oCount(cnt2), .oFull(full2), .oEmpty(empty2), .oBusy(busy2)
`ifdef PS2_CHAR_BUFFER_DIGIT_EN
      , .oLast_Digit()
`endif
   );

   // free-running clock
   always #5 CLOCK_50 = ~CLOCK_50;

   function automatic int cells(input int k);
      return m_cols[k] * m_rows[k];
   endfunction

   // every comparison in the bench goes through here
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compare_count++;
      if (observed !== expected) begin
         mismatch_count++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic stepCycle();
      @(posedge CLOCK_50);
      #1;
   endtask

   // apply one keystroke to the screen model, straight from the keyboard rules
   task automatic modelKey(input int k, input int key);
      int n;
      int left;
      n = cells(k);
      if (key >= 32 && key <= 126) begin
         if (m_cnt[k] == n && m_wrap[k] == 0) return;
         m_mem[k][m_pos[k]] = key;
         m_pos[k] = (m_pos[k] + 1) % n;
         if (m_cnt[k] < n) m_cnt[k]++;
      end else if (key == 8) begin
         if (m_cnt[k] == 0) return;
         m_pos[k] = (m_pos[k] + n - 1) % n;
         m_mem[k][m_pos[k]] = 32;
         m_cnt[k]--;
      end else if (key == 13) begin
         if (m_cnt[k] == n && m_wrap[k] == 0) return;
         left = m_cols[k] - (m_pos[k] % m_cols[k]);
         for (int i = 0; i < left; i++) begin
            m_mem[k][m_pos[k]] = 32;
            m_pos[k] = (m_pos[k] + 1) % n;
            if (m_cnt[k] < n) m_cnt[k]++;
         end
      end
   endtask

   task automatic modelClear();
      for (int k = 0; k < 3; k++) begin
         for (int a = 0; a < cells(k); a++) m_mem[k][a] = 32;
         m_pos[k] = 0;
         m_cnt[k] = 0;
      end
   endtask

   // one keystroke: strobe held for 'hold' cycles, then low for 'gap' cycles
   task automatic applyStimulus(input logic [7:0] key, input int hold_cycles, input int gap_cycles);
      ascii  = key;
      strobe = 1'b1;
      repeat (hold_cycles) stepCycle();
      strobe = 1'b0;
      ascii  = 8'($urandom);
      repeat (gap_cycles) stepCycle();
      for (int k = 0; k < 3; k++) modelKey(k, int'(key));
   endtask

   task automatic applyClear(input int hold_cycles);
      clear = 1'b1;
      repeat (hold_cycles) stepCycle();
      clear = 1'b0;
      repeat (200) stepCycle();
      modelClear();
   endtask

   task automatic getStatus(input int k, output logic [31:0] cnt, output logic [31:0] col,
                            output logic [31:0] row, output logic [31:0] fl,
                            output logic [31:0] em, output logic [31:0] bs);
      case (k)
         0: begin cnt = 32'(cnt0); col = 32'(col0); row = 32'(row0); fl = 32'(full0); em = 32'(empty0); bs = 32'(busy0); end
         1: begin cnt = 32'(cnt1); col = 32'(col1); row = 32'(row1); fl = 32'(full1); em = 32'(empty1); bs = 32'(busy1); end
         default: begin cnt = 32'(cnt2); col = 32'(col2); row = 32'(row2); fl = 32'(full2); em = 32'(empty2); bs = 32'(busy2); end
      endcase
   endtask

   // compare cursor, count and flags of all three buffers with the model
   task automatic checkStatus(input string tag);
      logic [31:0] cnt, col, row, fl, em, bs;
      int n;
      for (int k = 0; k < 3; k++) begin
         getStatus(k, cnt, col, row, fl, em, bs);
         n = cells(k);
         checkOutput($sformatf("%s.d%0d.count", tag, k), cnt, m_cnt[k]);
         checkOutput($sformatf("%s.d%0d.col", tag, k), col, m_pos[k] % m_cols[k]);
         checkOutput($sformatf("%s.d%0d.row", tag, k), row, m_pos[k] / m_cols[k]);
         checkOutput($sformatf("%s.d%0d.full", tag, k), fl, (m_cnt[k] == n) ? 1 : 0);
         checkOutput($sformatf("%s.d%0d.empty", tag, k), em, (m_cnt[k] == 0) ? 1 : 0);
         checkOutput($sformatf("%s.d%0d.busy", tag, k), bs, 0);
      end
   endtask

   // read every cell through the display port and compare the known ones
   task automatic dumpCheck(input string tag);
      for (int a = 0; a < 192; a++) begin
         rd_addr0 = 8'(a);
         if (a < 8) begin
            rd_addr1 = 3'(a);
            rd_addr2 = 3'(a);
         end
         stepCycle();
         if (m_mem[0][a] >= 0) checkOutput($sformatf("%s.d0.cell%0d", tag, a), 32'(rd_data0), m_mem[0][a]);
         if (a < 8) begin
            if (m_mem[1][a] >= 0) checkOutput($sformatf("%s.d1.cell%0d", tag, a), 32'(rd_data1), m_mem[1][a]);
            if (m_mem[2][a] >= 0) checkOutput($sformatf("%s.d2.cell%0d", tag, a), 32'(rd_data2), m_mem[2][a]);
         end
      end
   endtask

   // directed scenarios first, then a randomized keystroke stream
   initial begin
      rst_n    = 1'b0;
      strobe   = 1'b0;
      clear    = 1'b0;
      ascii    = 8'h00;
      rd_addr0 = '0;
      rd_addr1 = '0;
      rd_addr2 = '0;
      for (int k = 0; k < 3; k++) begin
         for (int a = 0; a < 192; a++) m_mem[k][a] = -1;
         m_pos[k] = 0;
         m_cnt[k] = 0;
      end

      // reset values, checked while reset is still asserted
      repeat (3) stepCycle();
      checkStatus("reset");
      checkOutput("reset.d0.rd_data", 32'(rd_data0), 0);
      checkOutput("reset.d1.rd_data", 32'(rd_data1), 0);
      checkOutput("reset.d2.rd_data", 32'(rd_data2), 0);
`ifdef PS2_CHAR_BUFFER_DIGIT_EN
      checkOutput("reset.digit", 32'(digit0), 0);
`endif
      rst_n = 1'b1;
      stepCycle();

      // a strobe held high for five cycles is one keystroke
      applyStimulus(8'h41, 5, 2);
      checkStatus("hold");
      rd_addr0 = 8'd0;
      stepCycle();
      checkOutput("hold.d0.cell0", 32'(rd_data0), 32'h41);

      // clear together with a strobe: clear wins, busy lasts one sweep
      ascii  = 8'h5A;
      strobe = 1'b1;
      clear  = 1'b1;
      stepCycle();
      clear = 1'b0;
      n0 = 0;
      n1 = 0;
      n2 = 0;
      for (int c = 0; c < 200; c++) begin
         if (busy0) n0++;
         if (busy1) n1++;
         if (busy2) n2++;
         stepCycle();
      end
      strobe = 1'b0;
      stepCycle();
      checkOutput("clear.d0.busy_cycles", n0, 192);
      checkOutput("clear.d1.busy_cycles", n1, 8);
      checkOutput("clear.d2.busy_cycles", n2, 8);
      modelClear();
      checkStatus("clear");
      dumpCheck("clear");

      // backspace past the start of the screen is a no-op
      applyStimulus(8'h61, 1, 1);
      applyStimulus(8'h62, 2, 1);
      applyStimulus(8'h08, 1, 1);
      applyStimulus(8'h08, 1, 1);
      checkStatus("bs2");
      applyStimulus(8'h08, 1, 1);
      checkStatus("bs3");

      // enter blank-fills the row; a keystroke during the fill is ignored
      applyStimulus(8'h78, 1, 1);
      ascii  = 8'h0D;
      strobe = 1'b1;
      stepCycle();
      strobe = 1'b0;
      stepCycle();
      ascii  = 8'h51;
      strobe = 1'b1;
      stepCycle();
      strobe = 1'b0;
      repeat (20) stepCycle();
      for (int k = 0; k < 3; k++) modelKey(k, 13);
      checkStatus("enter");
      dumpCheck("enter");

      // read and write of the same cell in one cycle returns the old byte
      rd_addr0 = 8'd16;
      stepCycle();
      ascii  = 8'h4B;
      strobe = 1'b1;
      stepCycle();
      checkOutput("rdw.old", 32'(rd_data0), m_mem[0][16]);
      stepCycle();
      strobe = 1'b0;
      for (int k = 0; k < 3; k++) modelKey(k, 8'h4B);
      checkOutput("rdw.new", 32'(rd_data0), m_mem[0][16]);
      stepCycle();
      checkStatus("rdw");

      // fill the small screens and push one more character
      applyClear(1);
      for (int i = 0; i < 9; i++) begin
         chars[i] = 8'($urandom_range(8'h21, 8'h7E));
         applyStimulus(chars[i], 1, 1);
         if (i == 7) begin
            checkOutput("fill8.d1.full", 32'(full1), 1);
            checkOutput("fill8.d2.full", 32'(full2), 1);
         end
      end
      rd_addr1 = 3'd0;
      rd_addr2 = 3'd0;
      stepCycle();
      checkOutput("wrap0.cell0", 32'(rd_data1), 32'(chars[0]));
      checkOutput("wrap1.cell0", 32'(rd_data2), 32'(chars[8]));
      checkStatus("fill9");
      dumpCheck("fill9");

`ifdef PS2_CHAR_BUFFER_DIGIT_EN
      applyStimulus(8'h37, 1, 1);
      checkOutput("digit.seven", 32'(digit0), 7);
      applyStimulus(8'h71, 1, 1);
      checkOutput("digit.q", 32'(digit0), 0);
`endif

      // reset in the middle of a clear sweep aborts it
      clear = 1'b1;
      stepCycle();
      clear = 1'b0;
      repeat (10) stepCycle();
      rst_n = 1'b0;
      stepCycle();
      checkOutput("midreset.d0.busy", 32'(busy0), 0);
      checkOutput("midreset.d0.count", 32'(cnt0), 0);
      rst_n = 1'b1;
      stepCycle();
      for (int k = 0; k < 3; k++) begin
         m_pos[k] = 0;
         m_cnt[k] = 0;
      end
      checkStatus("midreset");
      applyClear(2);
      checkStatus("reclear");

      // randomized keystroke stream against the model
      for (int t = 0; t < 300; t++) begin
         r = $urandom_range(0, 99);
         if (r < 5) begin
            applyClear($urandom_range(1, 2));
         end else begin
            if (r < 60)      code = 8'($urandom_range(8'h20, 8'h7E));
            else if (r < 80) code = 8'h08;
            else if (r < 88) code = 8'h0D;
            else             code = others[$urandom_range(0, 7)];
            hold = $urandom_range(1, 3);
            gap  = (code == 8'h0D) ? 18 : $urandom_range(1, 3);
            applyStimulus(code, hold, gap);
         end
         checkStatus($sformatf("rand%0d", t));
         if ((t % 50) == 49) dumpCheck($sformatf("rand%0d", t));
      end
      dumpCheck("final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
      $finish;
   end

endmodule
